imem_cache: RTL and testbench

- Direct-mapped, read-only instruction cache between the pipeline's fetch PC and a multi-cycle backing instruction memory.
- Supplies `instruction` combinationally on a hit, so fetch timing is unchanged.
- On a miss, asserts `stall`, which is ORed into the fetch/decode stall, and refills one line word-by-word over a req/ready interface.
- Sits directly upstream of the datapath's `instruction` input.

---
 rtl/imem_cache_pkg.sv | 34 +++
 rtl/imem_cache_store.sv | 57 +++++
 rtl/imem_cache.sv | 146 ++++++++++++++
 tb/tb_imem_cache.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_cache_pkg.sv
// imem_cache_pkg: shared types and address-field helpers for the
// direct-mapped instruction cache.
//   icache_state_e : refill FSM states
//   ic_tag/ic_index/ic_word : split a fetch address into cache fields,
//     given IB = log2(LINES) and WB = log2(WORDS). Results are
//     right-aligned in 32 bits; callers size-cast to the field width.
package imem_cache_pkg;

  typedef enum logic {
    IC_IDLE   = 1'b0,
    IC_REFILL = 1'b1
  } icache_state_e;

  // Word offset inside a line: addr[WB+1:2]
  function automatic logic [31:0] ic_word(input logic [31:0] addr,
                                          input int unsigned  wb);
    return (addr >> 2) & ((32'd1 << wb) - 32'd1);
  endfunction

  // Line index: addr[IB+WB+1:WB+2]
  function automatic logic [31:0] ic_index(input logic [31:0] addr,
                                           input int unsigned  ib,
                                           input int unsigned  wb);
    return (addr >> (wb + 2)) & ((32'd1 << ib) - 32'd1);
  endfunction

  // Tag: everything above the index
  function automatic logic [31:0] ic_tag(input logic [31:0] addr,
                                         input int unsigned  ib,
                                         input int unsigned  wb);
    return addr >> (ib + wb + 2);
  endfunction

endpackage

// File: rtl/imem_cache_store.sv
// imem_cache_store: tag, data and valid arrays of the instruction cache.
//   clk_i, rst_i     : clock, synchronous active-high reset (clears valid only)
//   flush_i          : clears every valid bit at the clock edge
//   rd_index_i/rd_word_i -> rd_valid_o, rd_tag_o, rd_data_o : async lookup
//   data_we_i, wr_index_i, wr_word_i, wr_data_i : one refill word per cycle
//   line_we_i, wr_tag_i : commits the tag and sets valid for wr_index_i
// Tag and data arrays are intentionally not reset.
module imem_cache_store #(
  parameter int unsigned  LINES = 16,
  parameter int unsigned  WORDS = 4,
  localparam int unsigned IB    = $clog2(LINES),
  localparam int unsigned WB    = $clog2(WORDS),
  localparam int unsigned TW    = 32 - IB - WB - 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic [IB-1:0] rd_index_i,
  input  logic [WB-1:0] rd_word_i,
  output logic          rd_valid_o,
  output logic [TW-1:0] rd_tag_o,
  output logic [31:0]   rd_data_o,
  input  logic          data_we_i,
  input  logic [IB-1:0] wr_index_i,
  input  logic [WB-1:0] wr_word_i,
  input  logic [31:0]   wr_data_i,
  input  logic          line_we_i,
  input  logic [TW-1:0] wr_tag_i
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES][WORDS];

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_word_i];

  // Flush is applied after the line commit so a flush on the final
  // refill beat leaves that line invalid.
  always_comb begin
    valid_d = valid_q;
    if (line_we_i) valid_d[wr_index_i] = 1'b1;
    if (flush_i)   valid_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (data_we_i) data_q[wr_index_i][wr_word_i] <= wr_data_i;
    if (line_we_i) tag_q[wr_index_i] <= wr_tag_i;
  end

endmodule

// File: rtl/imem_cache.sv
// imem_cache: direct-mapped, read-only instruction cache in front of a
// multi-cycle instruction memory.
//   clock, reset : clock, synchronous active-high reset
//   pc           : fetch address (pc[1:0] ignored)
//   flush        : one-cycle pulse, invalidates every line
//   instruction  : word at pc on a hit, 0 while stalled or in reset
//   stall        : high while pc misses or a refill is running
//   mem_req/mem_addr/mem_ready/mem_rdata : refill beat interface
//   hit_count/miss_count : saturating event counters
//
// Refill handshake: mem_req is high for the whole refill and mem_addr is
// held stable until a cycle with mem_req & mem_ready; in that cycle the
// beat is accepted and mem_rdata is captured. mem_ready without mem_req
// (and any mem_ready during reset) is ignored.
module imem_cache
  import imem_cache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] instruction,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IB = $clog2(LINES);
  localparam int unsigned WB = $clog2(WORDS);
  localparam int unsigned TW = 32 - IB - WB - 2;

  icache_state_e state_q, state_d;
  logic [WB-1:0] beat_q, beat_d;
  logic [TW-1:0] miss_tag_q, miss_tag_d;
  logic [IB-1:0] miss_index_q, miss_index_d;
  logic [31:0]   hit_count_q, hit_count_d;
  logic [31:0]   miss_count_q, miss_count_d;

  logic [TW-1:0] pc_tag;
  logic [IB-1:0] pc_index;
  logic [WB-1:0] pc_word;

  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_data;
  logic          hit;
  logic          data_we, line_we;

  assign pc_tag   = TW'(ic_tag(pc, IB, WB));
  assign pc_index = IB'(ic_index(pc, IB, WB));
  assign pc_word  = WB'(ic_word(pc, WB));

  imem_cache_store #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_store (
    .clk_i      (clock),
    .rst_i      (reset),
    .flush_i    (flush),
    .rd_index_i (pc_index),
    .rd_word_i  (pc_word),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .data_we_i  (data_we),
    .wr_index_i (miss_index_q),
    .wr_word_i  (beat_q),
    .wr_data_i  (mem_rdata),
    .line_we_i  (line_we),
    .wr_tag_i   (miss_tag_q)
  );

  assign hit         = (state_q == IC_IDLE) && rd_valid && (rd_tag == pc_tag);
  assign stall       = reset ? 1'b0 : !hit;
  assign instruction = (reset || !hit) ? 32'd0 : rd_data;
  assign mem_addr    = {miss_tag_q, miss_index_q, beat_q, 2'b00};
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    mem_req      = 1'b0;
    data_we      = 1'b0;
    line_we      = 1'b0;

    case (state_q)
      IC_IDLE: begin
        if (hit) begin
          if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
        end else begin
          // A coinciding flush still clears valid; the refill starts anyway.
          miss_tag_d   = pc_tag;
          miss_index_d = pc_index;
          beat_d       = '0;
          state_d      = IC_REFILL;
          if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
        end
      end
      IC_REFILL: begin
        mem_req = 1'b1;
        // Writes are suppressed in a reset cycle so an abandoned burst
        // leaves nothing behind.
        if (mem_ready && !reset) begin
          data_we = 1'b1;
          beat_d  = beat_q + WB'(1);
          if (beat_q == WB'(WORDS - 1)) begin
            line_we = 1'b1;
            state_d = IC_IDLE;
          end
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IC_IDLE;
      beat_q       <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_imem_cache.sv
module tb_imem_cache;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset, flush, mem_ready;
  logic        stall, mem_req;
  logic [31:0] pc, instruction, mem_addr, mem_rdata, hit_count, miss_count;

  logic [31:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int beats_seen = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ K;

  imem_cache #(.LINES(16), .WORDS(4)) dut (
    .clock       (clk),
    .reset       (reset),
    .pc          (pc),
    .flush       (flush),
    .instruction (instruction),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #3;
  endtask

  task automatic expect_refill(input logic [31:0] base);
    for (int w = 0; w < 4; w++) exp_q.push_back(base + 32'(w * 4));
  endtask

  // One refill cycle driven by hand: must be stalled with a request out.
  task automatic manual_beat(input string tag);
    mid();
    check({tag, "_stall"}, 32'(stall), 32'd1);
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    next();
  endtask

  // Measures the stall window from the current cycle, then checks the hit.
  task automatic run_refill(input string tag, input logic [31:0] addr, input int exp_len);
    int n;
    n = 0;
    mid();
    while (stall && n < 50) begin
      n++;
      next();
      mid();
    end
    exp_misses++;
    check({tag, "_stall_cycles"}, 32'(n), 32'(exp_len));
    check({tag, "_instr"}, instruction, addr ^ K);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_miss_count"}, miss_count, 32'(exp_misses));
    check({tag, "_hit_count"}, hit_count, 32'(exp_hits));
    next();
    exp_hits++;
  endtask

  // ---------------- scoreboard: refill beat addresses ----------------
  always @(negedge clk) begin
    if (mem_req && mem_ready && !reset) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL beat_unexpected observed=%h expected=none", mem_addr);
      end else begin
        check("beat_addr", mem_addr, exp_q.pop_front());
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] pat;
    int nb;

    reset = 1'b1; pc = 32'd0; flush = 1'b0; mem_ready = 1'b0;
    next();
    next();
    mid();
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_req", 32'(mem_req), 32'd0);
    check("reset_instr", instruction, 32'd0);
    check("reset_hits", hit_count, 32'd0);
    check("reset_misses", miss_count, 32'd0);
    next();
    reset = 1'b0;

    // Cold miss
    pc = 32'h40; mem_ready = 1'b1;
    expect_refill(32'h40);
    run_refill("cold", 32'h40, 5);

    // Hits across the filled line
    for (int i = 0; i < 4; i++) begin
      pc = 32'h40 + 32'(i * 4);
      mid();
      check("sweep_stall", 32'(stall), 32'd0);
      check("sweep_instr", instruction, pc ^ K);
      check("sweep_req", 32'(mem_req), 32'd0);
      check("sweep_hits", hit_count, 32'(exp_hits));
      next();
      exp_hits++;
    end
    mid();
    check("sweep_hits_total", hit_count, 32'd5);
    next();
    exp_hits++;

    // Conflict eviction: same index, different tag, and back
    pc = 32'h140;
    expect_refill(32'h140);
    run_refill("evict_a", 32'h140, 5);
    pc = 32'h40;
    expect_refill(32'h40);
    run_refill("evict_b", 32'h40, 5);
    check("evict_miss_total", miss_count, 32'd3);

    // Backpressure: ready pattern 0,0,1,0,1,1,0,1
    pc = 32'h80; mem_ready = 1'b0;
    expect_refill(32'h80);
    beats_seen = 0;
    mid();
    check("bp_detect_stall", 32'(stall), 32'd1);
    next();
    exp_misses++;
    pat = 8'b1011_0100;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = pat[i];
      mid();
      check("bp_stall", 32'(stall), 32'd1);
      check("bp_addr_hold", mem_addr, 32'h80 + 32'(nb * 4));
      if (pat[i]) nb++;
      next();
    end
    mem_ready = 1'b1;
    mid();
    check("bp_release", 32'(stall), 32'd0);
    check("bp_instr", instruction, 32'h80 ^ K);
    check("bp_writes", 32'(beats_seen), 32'd4);
    check("bp_queue_drained", 32'(exp_q.size()), 32'd0);
    check("bp_miss_count", miss_count, 32'(exp_misses));
    next();
    exp_hits++;

    // Flush on the final beat leaves the line invalid
    pc = 32'hC0;
    expect_refill(32'hC0);
    mid();
    check("fl_detect_stall", 32'(stall), 32'd1);
    next();
    exp_misses++;
    manual_beat("fl_b0");
    manual_beat("fl_b1");
    manual_beat("fl_b2");
    flush = 1'b1;
    manual_beat("fl_b3");
    flush = 1'b0;
    expect_refill(32'hC0);
    run_refill("flush_last", 32'hC0, 5);

    // Flush in the middle of a burst does not abort it
    pc = 32'h100;
    expect_refill(32'h100);
    mid();
    check("fm_detect_stall", 32'(stall), 32'd1);
    next();
    exp_misses++;
    manual_beat("fm_b0");
    flush = 1'b1;
    manual_beat("fm_b1");
    flush = 1'b0;
    manual_beat("fm_b2");
    manual_beat("fm_b3");
    mid();
    check("fm_line_valid", 32'(stall), 32'd0);
    check("fm_instr", instruction, 32'h100 ^ K);
    check("fm_queue_drained", 32'(exp_q.size()), 32'd0);
    next();
    exp_hits++;

    // Reset after two beats abandons the burst
    pc = 32'h300;
    expect_refill(32'h300);
    mid();
    next();
    exp_misses++;
    manual_beat("rm_b0");
    manual_beat("rm_b1");
    reset = 1'b1;
    mem_ready = 1'b0;
    next();
    mid();
    check("rm_req", 32'(mem_req), 32'd0);
    check("rm_stall", 32'(stall), 32'd0);
    check("rm_instr", instruction, 32'd0);
    check("rm_hits", hit_count, 32'd0);
    check("rm_misses", miss_count, 32'd0);
    check("rm_pending_beats", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    exp_hits = 0;
    exp_misses = 0;
    next();
    reset = 1'b0;
    mem_ready = 1'b1;
    expect_refill(32'h300);
    run_refill("after_reset", 32'h300, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
